// File: rtl/episode_trace_logger_if.sv
// rtl/episode_trace_logger_if.sv - trace log output stream bundle (head entry, valid, ready)
interface episode_trace_logger_if;
    logic [15:0] log_data;
    logic        log_valid;
    logic        log_ready;

    // producer side: the logger presents entries and samples the consumer's ready
    modport master (
        output log_data,
        output log_valid,
        input  log_ready
    );

    // consumer side
    modport slave (
        input  log_data,
        input  log_valid,
        output log_ready
    );
endinterface

// File: rtl/episode_trace_logger.sv
// rtl/episode_trace_logger.sv - step trace FIFO with sticky overflow; optional stats under TRACE_STATS_EN
module episode_trace_logger #(
    parameter int DEPTH      = 32,
    parameter int GOAL_STATE = 25
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         print,
    input  logic [5:0]                   current_st,
    input  logic [9:0]                   episode,
    episode_trace_logger_if.master       log,
    output logic [6:0]                   fifo_count,
    output logic                         overflow,
    output logic [9:0]                   goal_count,
    output logic [4:0]                   last_steps
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full  = (fifo_count == 7'(DEPTH));
    assign pop   = log.log_valid && log.log_ready;
    // a full FIFO still takes a write when the head leaves on the same edge
    assign wr_en = print && (!full || pop);

    assign log.log_valid = (fifo_count != 7'd0);
    // gated so the head reads as zero whenever nothing valid is stored
    assign log.log_data  = log.log_valid ? mem[rd_ptr] : 16'h0000;

    // entry storage; contents need no reset because log_valid qualifies them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {episode, current_st};
        end
    end

    // pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 7'd0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 7'd1;
                2'b01:   fifo_count <= fifo_count - 7'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (print && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef TRACE_STATS_EN
    logic [4:0] step_cnt;
    logic [9:0] prev_episode;

    // per-episode step counting and goal tally, independent of FIFO state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt     <= 5'd0;
            prev_episode <= 10'd0;
            last_steps   <= 5'd0;
            goal_count   <= 10'd0;
        end else begin
            prev_episode <= episode;
            if (episode != prev_episode) begin
                last_steps <= step_cnt;
                step_cnt   <= print ? 5'd1 : 5'd0;
            end else if (print && step_cnt != 5'd31) begin
                step_cnt <= step_cnt + 5'd1;
            end
            if (print && current_st == 6'(GOAL_STATE) && goal_count != 10'd1023) begin
                goal_count <= goal_count + 10'd1;
            end
        end
    end
`else
    assign goal_count = 10'd0;
    assign last_steps = 5'd0;
`endif

endmodule

// File: tb/tb_episode_trace_logger.sv
// tb/tb_episode_trace_logger.sv - directed self-checking bench for episode_trace_logger
module tb_episode_trace_logger;

`ifdef TRACE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       print;
    logic [5:0] current_st;
    logic [9:0] episode;
    logic [6:0] fifo_count;
    logic       overflow;
    logic [9:0] goal_count;
    logic [4:0] last_steps;

    episode_trace_logger_if log_if ();

    episode_trace_logger #(.DEPTH(32), .GOAL_STATE(25)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .print      (print),
        .current_st (current_st),
        .episode    (episode),
        .log        (log_if),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .goal_count (goal_count),
        .last_steps (last_steps)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        print            = 1'b0;
        current_st       = 6'd0;
        episode          = 10'd0;
        log_if.log_ready = 1'b0;
        #1;
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_valid", 32'(log_if.log_valid), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_goal", 32'(goal_count), 32'd0);
        check("reset_last", 32'(last_steps), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ready with nothing stored must not disturb the FIFO
        log_if.log_ready = 1'b1;
        tick();
        check("ready_empty_count", 32'(fifo_count), 32'd0);
        check("ready_empty_valid", 32'(log_if.log_valid), 32'd0);
        log_if.log_ready = 1'b0;

        // three captures in episode 1; first visible one cycle after its edge
        episode = 10'd1;
        print   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            current_st = 6'(i + 1);
            q.push_back({10'd1, 6'(i + 1)});
            tick();
            if (i == 0) begin
                check("first_valid", 32'(log_if.log_valid), 32'd1);
                check("first_data", 32'(log_if.log_data), 32'h0041);
            end
        end
        check("three_count", 32'(fifo_count), 32'd3);
        check("three_head", 32'(log_if.log_data), 32'h0041);

        // fill to 32 entries, states cycling 1..25
        for (int i = 3; i < 32; i++) begin
            current_st = 6'((i % 25) + 1);
            q.push_back({10'd1, 6'((i % 25) + 1)});
            tick();
        end
        check("full_count", 32'(fifo_count), 32'd32);
        check("full_head_stable", 32'(log_if.log_data), 32'h0041);
        check("full_overflow", 32'(overflow), 32'd0);
        check("fill_goal", 32'(goal_count), STATS ? 32'd1 : 32'd0);
        check("fill_last", 32'(last_steps), 32'd0);

        // full + pop + write on one edge: accepted at tail, no overflow
        log_if.log_ready = 1'b1;
        current_st       = 6'd7;
        tick();
        void'(q.pop_front());
        q.push_back(16'h0047);
        check("pushpop_count", 32'(fifo_count), 32'd32);
        check("pushpop_overflow", 32'(overflow), 32'd0);
        check("pushpop_head", 32'(log_if.log_data), 32'h0042);

        // full without pop: dropped, overflow sticks
        log_if.log_ready = 1'b0;
        current_st       = 6'd9;
        tick();
        check("drop_count", 32'(fifo_count), 32'd32);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_head", 32'(log_if.log_data), 32'h0042);
        print = 1'b0;
        tick();
        check("overflow_sticky", 32'(overflow), 32'd1);

        // drain 22 entries in order, leaving 10
        log_if.log_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            check($sformatf("drain_%0d", i), 32'(log_if.log_data), 32'(q[0]));
            tick();
            void'(q.pop_front());
        end
        log_if.log_ready = 1'b0;
        check("ten_count", 32'(fifo_count), 32'd10);
        check("ten_head", 32'(log_if.log_data), 32'(q[0]));
        check("ten_overflow", 32'(overflow), 32'd1);

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count", 32'(fifo_count), 32'd0);
        check("async_valid", 32'(log_if.log_valid), 32'd0);
        check("async_data", 32'(log_if.log_data), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        check("async_goal", 32'(goal_count), 32'd0);
        check("async_last", 32'(last_steps), 32'd0);
        q.delete();
        tick();
        rst_n = 1'b1;

        // episode 3: seven steps, goal state on the last
        episode = 10'd3;
        print   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            current_st = (i == 6) ? 6'd25 : 6'(i + 1);
            q.push_back({10'd3, current_st});
            tick();
            if (i == 0) begin
                check("post_reset_valid", 32'(log_if.log_valid), 32'd1);
                check("post_reset_data", 32'(log_if.log_data), 32'h00C1);
            end
            if (i == 5) begin
                check("pre_goal", 32'(goal_count), 32'd0);
            end
        end
        check("ep3_count", 32'(fifo_count), 32'd7);
        check("ep3_goal", 32'(goal_count), STATS ? 32'd1 : 32'd0);
        check("ep3_last", 32'(last_steps), 32'd0);

        // episode boundary with a capture
        episode    = 10'd4;
        current_st = 6'd1;
        q.push_back(16'h0101);
        tick();
        check("ep4_last", 32'(last_steps), STATS ? 32'd7 : 32'd0);
        check("ep4_goal", 32'(goal_count), STATS ? 32'd1 : 32'd0);
        check("ep4_count", 32'(fifo_count), 32'd8);
        print = 1'b0;

        // final drain in write order
        log_if.log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("final_%0d", i), 32'(log_if.log_data), 32'(q[0]));
            tick();
            void'(q.pop_front());
        end
        check("end_count", 32'(fifo_count), 32'd0);
        check("end_valid", 32'(log_if.log_valid), 32'd0);
        check("end_overflow", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/episode_trace_logger.md
EPISODE_TRACE_LOGGER -- requirements
Module: episode_trace_logger

Interface
REQ-001 Parameter DEPTH, default 32, FIFO entry count; power of two, 4..64.
REQ-002 Parameter GOAL_STATE, default 25, grid state index counted as goal reached.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 print  input  1  control-unit step-valid flag; high = current_st is a live step.
REQ-006 current_st  input  6  grid state of the current step, 1..25.
REQ-007 episode  input  10  episode counter from the control unit.
REQ-008 log_data  output  16  FIFO head entry {episode[9:0], state[5:0]}.
REQ-009 log_valid  output  1  FIFO non-empty; log_data holds a valid entry.
REQ-010 log_ready  input  1  consumer accepts head entry when high with log_valid.
REQ-011 fifo_count  output  7  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: a capture was dropped.
REQ-013 goal_count  output  10  goal captures since reset (TRACE_STATS_EN only).
REQ-014 last_steps  output  5  step count of most recently completed episode (TRACE_STATS_EN only).

Function
REQ-015 Capture: every rising edge with print=1 SHALL produce one write request of {episode, current_st}.
REQ-016 Write accepted when fifo_count<DEPTH, or when fifo_count==DEPTH and a pop occurs the same cycle.
REQ-017 Write request rejected when full with no same-cycle pop; entry discarded, overflow set to 1 the following cycle and held until reset.
REQ-018 Pop occurs on an edge with log_valid=1 and log_ready=1; log_ready while log_valid=0 SHALL have no effect.
REQ-019 No fall-through: an entry written into an empty FIFO SHALL appear on log_data with log_valid=1 on the cycle after the write edge (1-cycle latency).
REQ-020 log_data SHALL remain stable while log_valid=1 and log_ready=0.
REQ-021 Entries SHALL pop in write order; read and write pointers wrap modulo DEPTH.
REQ-022 fifo_count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-023 Dropped captures SHALL NOT alter pointers, fifo_count, or existing entries.

Reset
REQ-024 rst_n=0 SHALL immediately clear the pointers, fifo_count, overflow, goal_count, last_steps, the step counter and the stored previous episode; log_valid=0.
REQ-025 Mid-operation reset SHALL discard all stored entries; log_data content after reset is don't-care while log_valid=0.
REQ-026 First capture is accepted on the first edge after rst_n deasserts with print=1.

Configuration
REQ-027 Macro TRACE_STATS_EN: when defined, the statistics logic of REQ-028..031 is compiled in; when undefined, goal_count and last_steps are tied to 0 and no statistics flops exist.
REQ-028 Step counter increments on every edge with print=1 (accepted or dropped), saturating at 31.
REQ-029 Episode boundary: on an edge where episode differs from the stored previous episode, last_steps SHALL load the step counter value and the step counter SHALL restart: 1 if print=1 that edge, else 0. The stored previous episode updates every edge.
REQ-030 goal_count increments on each edge with print=1 and current_st==GOAL_STATE, saturating at 1023.
REQ-031 Statistics SHALL update regardless of FIFO full/overflow state.

Verification
REQ-032 Reset, then print=1 for 3 cycles with episode=1 and states 1,2,3 and log_ready=0 -> fifo_count=3, log_data=0x0041, log_valid=1 one cycle after the first capture.
REQ-033 Fill to DEPTH=32 with log_ready=0, then one more capture -> fifo_count stays 32, overflow=1 next cycle, head entry unchanged.
REQ-034 Full FIFO with log_ready=1 and print=1 on the same edge -> fifo_count stays 32, new entry stored at tail, overflow stays 0.
REQ-035 With TRACE_STATS_EN: 7 print cycles in episode 3, then episode=4 with print=1 -> last_steps=7, goal_count increments once on the single capture with current_st=25.
REQ-036 Assert rst_n=0 mid-stream with fifo_count=10 and overflow=1 -> all outputs 0 asynchronously; a later capture is seen on log_data 1 cycle after its write edge.
REQ-037 Without TRACE_STATS_EN: run REQ-035 stimulus -> goal_count=0 and last_steps=0 throughout; FIFO behaviour identical to REQ-032..034.
